// File: rtl/dec2bin_parser_if.sv
// Byte-in / parsed-value-out bundle between the UART RX side and the config logic.
interface dec2bin_parser_if #(
  parameter int unsigned WIDTH = 32
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             err_valid;
  logic [1:0]       err_code;
  logic             busy;

  // Byte source (UART RX / testbench)
  modport master (
    output rx_data, rx_valid,
    input  value, value_valid, err_valid, err_code, busy
  );

  // Parser
  modport slave (
    input  rx_data, rx_valid,
    output value, value_valid, err_valid, err_code, busy
  );
endinterface

// File: rtl/dec2bin_parser.sv
// ASCII decimal line parser: digits accumulate into a binary value,
// CR/LF terminates a line, bad lines are reported once and then discarded.
module dec2bin_parser #(
  parameter int unsigned MAX_DIGITS = 10,
  parameter int unsigned WIDTH      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  dec2bin_parser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned EXT_W = WIDTH + 4;

  localparam logic [1:0] ERR_CHAR  = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam logic [1:0] ERR_COUNT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;

  logic             is_digit;
  logic             is_term;
  logic [3:0]       digit;
  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] mac;
  logic             mac_ovf;

  // Byte classification and acc*10+d with headroom bits for overflow detection
  always_comb begin
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    digit    = bus.rx_data[3:0];
    acc_ext  = EXT_W'(acc_q);
    mac      = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit);
    mac_ovf  = |mac[EXT_W-1:WIDTH];
  end

  // Next-state and output decode; pulses default low, value/err_code hold
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;

    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (is_digit) begin
            acc_d   = WIDTH'(digit);
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end else if (!is_term) begin
            err_code_d  = ERR_CHAR;
            err_valid_d = 1'b1;
            state_d     = DISCARD;
          end
        end
        ACCUM: begin
          if (is_digit) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              err_code_d  = ERR_COUNT;
              err_valid_d = 1'b1;
              state_d     = DISCARD;
            end else if (mac_ovf) begin
              err_code_d  = ERR_OVF;
              err_valid_d = 1'b1;
              state_d     = DISCARD;
            end else begin
              acc_d = mac[WIDTH-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            value_d       = acc_q;
            value_valid_d = 1'b1;
            state_d       = IDLE;
          end else begin
            err_code_d  = ERR_CHAR;
            err_valid_d = 1'b1;
            state_d     = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= 2'b00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dec2bin_parser.sv
// Self-checking bench for dec2bin_parser: table of lines with hand-derived
// outcomes, pulses checked through a timed scoreboard, plus an async-reset sequence.
module tb_dec2bin_parser;

  logic clk;
  logic reset_n;

  dec2bin_parser_if #(.WIDTH(32)) bus ();

  dec2bin_parser #(.MAX_DIGITS(10), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       txt;
    int          trig;       // index of byte that triggers a pulse, -1 for none
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] val;        // value output after the line (and pulse value)
    bit          busy_after;
    bit          gap;        // idle cycle and output check after the line
  } vec_t;

  typedef struct {
    int          due;
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          edge_cnt = 0;
  logic [1:0]  last_code = 2'b00;
  vec_t        vecs[16];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string t, input int tr, input bit e,
                              input logic [1:0] c, input logic [31:0] v,
                              input bit b, input bit g);
    vec_t r;
    r.txt = t; r.trig = tr; r.is_err = e; r.code = c;
    r.val = v; r.busy_after = b; r.gap = g;
    return r;
  endfunction

  // Pulse monitor: every pulse must match the scoreboard head at its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (bus.value_valid || bus.err_valid) begin
      chk("pulse_exclusive", 32'(bus.value_valid & bus.err_valid), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got vv=%0b ev=%0b expected no pulse at edge %0d",
                 bus.value_valid, bus.err_valid, edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", 32'(edge_cnt), 32'(e.due));
        chk("pulse_kind", 32'(bus.err_valid), 32'(e.is_err));
        if (e.is_err) chk("err_code", 32'(bus.err_code), 32'(e.code));
        else          chk("value", bus.value, e.val);
      end
    end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_pulse: got none expected is_err=%0b due edge %0d", e.is_err, e.due);
    end
  end

  task automatic send_line(input vec_t v, input int idx);
    exp_t e;
    for (int i = 0; i < v.txt.len(); i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = v.txt[i];
      if (i == v.trig) begin
        e.due = edge_cnt + 1; e.is_err = v.is_err; e.code = v.code; e.val = v.val;
        sb.push_back(e);
      end
    end
    if (v.gap) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      if (v.is_err && v.trig >= 0) last_code = v.code;
      chk($sformatf("v%0d_value", idx), bus.value, v.val);
      chk($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'(v.busy_after));
      chk($sformatf("v%0d_err_code", idx), 32'(bus.err_code), 32'(last_code));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by 500000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk("0\015",            1, 1'b0, 2'b00, 32'd0,          1'b0, 1'b1);
    vecs[1]  = mk("4294967295\015",  10, 1'b0, 2'b00, 32'hFFFF_FFFF,  1'b0, 1'b1);
    vecs[2]  = mk("4294967296",       9, 1'b1, 2'b10, 32'hFFFF_FFFF,  1'b1, 1'b1);
    vecs[3]  = mk("\n\n",            -1, 1'b0, 2'b00, 32'hFFFF_FFFF,  1'b0, 1'b1);
    vecs[4]  = mk("12a4\015\n",       2, 1'b1, 2'b01, 32'hFFFF_FFFF,  1'b0, 1'b1);
    vecs[5]  = mk("7\n",              1, 1'b0, 2'b00, 32'd7,          1'b0, 1'b1);
    vecs[6]  = mk("00000000012\015", 10, 1'b1, 2'b11, 32'd7,          1'b0, 1'b1);
    vecs[7]  = mk("0000000012\015",  10, 1'b0, 2'b00, 32'd12,         1'b0, 1'b1);
    vecs[8]  = mk("\015\n\015",      -1, 1'b0, 2'b00, 32'd12,         1'b0, 1'b1);
    vecs[9]  = mk("5\015",            1, 1'b0, 2'b00, 32'd5,          1'b0, 1'b0);
    vecs[10] = mk("6\015",            1, 1'b0, 2'b00, 32'd6,          1'b0, 1'b1);
    vecs[11] = mk("x99\015",          0, 1'b1, 2'b01, 32'd6,          1'b0, 1'b1);
    vecs[12] = mk("99999999999\015",  9, 1'b1, 2'b10, 32'd6,          1'b0, 1'b1);
    vecs[13] = mk("4294967300\015",   9, 1'b1, 2'b10, 32'd6,          1'b0, 1'b1);
    vecs[14] = mk("123",             -1, 1'b0, 2'b00, 32'd6,          1'b1, 1'b1);
    vecs[15] = mk("4\015",            1, 1'b0, 2'b00, 32'd1234,       1'b0, 1'b1);

    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_value", bus.value, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    chk("rst_pulses", 32'({bus.value_valid, bus.err_valid}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 16; k++) send_line(vecs[k], k);

    // Reset in the middle of a partial line drops it without any pulse
    send_line(mk("123", -1, 1'b0, 2'b00, 32'd1234, 1'b1, 1'b1), 16);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_value", bus.value, 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_err_code", 32'(bus.err_code), 32'd0);
    chk("midrst_pulses", 32'({bus.value_valid, bus.err_valid}), 32'd0);
    last_code = 2'b00;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    send_line(mk("45\015", 2, 1'b0, 2'b00, 32'd45, 1'b0, 1'b1), 17);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
